// File: rtl/fir_pkg.sv
// Shared parameters and loader state type for the 21-tap audio FIR and its coefficient loader.
package fir_pkg;

   localparam int N_TAPS = 21;
   localparam int COEF_W = 16;
   localparam int ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      HIGH,
      FINISH
   } ldr_state_t;

endpackage

// File: rtl/fir_coef_buf.sv
// N_TAPS x COEF_W coefficient register file: reset-to-zero synchronous write, asynchronous read.
module fir_coef_buf
   import fir_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [COEF_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [COEF_W-1:0] rd_data
);

   logic [COEF_W-1:0] mem [N_TAPS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_TAPS; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_coef_loader.sv
// Serially shifts the coefficient buffer into the FIR coefficient chain via coef_out/coef_clk.
// Optional running checksum output coef_sum when FIR_COEF_CHECKSUM_EN is defined.
//
// state  | meaning
// IDLE   | buffer writable, waiting for load_start
// SETUP  | coef_out holds buf[idx], coef_clk low for HALF cycles
// HIGH   | coef_clk high for HALF cycles, coef_out stable
// FINISH | done pulse, busy low, back to IDLE
module fir_coef_loader
   import fir_pkg::*;
#(
   parameter int HALF = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [COEF_W-1:0] wr_data,
   input  logic              load_start,
   output logic              busy,
   output logic              done,
   output logic              wr_err,
   output logic [COEF_W-1:0] coef_out,
   output logic              coef_clk
`ifdef FIR_COEF_CHECKSUM_EN
   ,output logic [COEF_W-1:0] coef_sum
`endif
);

   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(HALF - 1);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N_TAPS - 1);

   ldr_state_t        state, state_n;
   logic [ADDR_W-1:0] idx, idx_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              busy_n, done_n, wr_err_n, coef_clk_n;
   logic [COEF_W-1:0] coef_out_n;
   logic              wr_ok, addr_ok;
   logic [ADDR_W-1:0] rd_addr;
   logic [COEF_W-1:0] rd_data, next_word;
`ifdef FIR_COEF_CHECKSUM_EN
   logic [COEF_W-1:0] sum_n;
`endif

   fir_coef_buf u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign addr_ok = ({1'b0, wr_addr} < (ADDR_W + 1)'(N_TAPS));
   assign wr_ok   = wr_en && addr_ok && (state == IDLE);

   // Read address is the word about to enter SETUP; a write to that word in the
   // start cycle is forwarded so it makes it into this load.
   always_comb begin
      rd_addr = LAST;
      if (state != IDLE && idx != '0) rd_addr = idx - 1'b1;
      next_word = rd_data;
      if (wr_ok && wr_addr == LAST) next_word = wr_data;
   end

   always_comb begin
      state_n    = state;
      idx_n      = idx;
      cnt_n      = cnt;
      busy_n     = busy;
      done_n     = 1'b0;
      wr_err_n   = wr_en && !wr_ok;
      coef_out_n = coef_out;
      coef_clk_n = coef_clk;
`ifdef FIR_COEF_CHECKSUM_EN
      sum_n      = coef_sum;
`endif
      case (state)
         IDLE: begin
            if (load_start) begin
               state_n    = SETUP;
               idx_n      = LAST;
               cnt_n      = HALF_M1;
               busy_n     = 1'b1;
               coef_out_n = next_word;
`ifdef FIR_COEF_CHECKSUM_EN
               sum_n      = next_word;
`endif
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               state_n    = HIGH;
               cnt_n      = HALF_M1;
               coef_clk_n = 1'b1;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         HIGH: begin
            if (cnt == '0) begin
               coef_clk_n = 1'b0;
               cnt_n      = HALF_M1;
               if (idx == '0) begin
                  state_n = FINISH;
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
               end else begin
                  state_n    = SETUP;
                  idx_n      = idx - 1'b1;
                  coef_out_n = next_word;
`ifdef FIR_COEF_CHECKSUM_EN
                  sum_n      = coef_sum + next_word;
`endif
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         FINISH: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wr_err   <= 1'b0;
         coef_out <= '0;
         coef_clk <= 1'b0;
`ifdef FIR_COEF_CHECKSUM_EN
         coef_sum <= '0;
`else
         // no checksum register in this build
`endif
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         cnt      <= cnt_n;
         busy     <= busy_n;
         done     <= done_n;
         wr_err   <= wr_err_n;
         coef_out <= coef_out_n;
         coef_clk <= coef_clk_n;
`ifdef FIR_COEF_CHECKSUM_EN
         coef_sum <= sum_n;
`endif
      end
   end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Scoreboard bench for fir_coef_loader; checks coef_sum too when FIR_COEF_CHECKSUM_EN is defined.
module tb_fir_coef_loader;
   import fir_pkg::*;

   localparam int HALF = 2;
   localparam int LAT  = 2 * HALF * N_TAPS + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [COEF_W-1:0] wr_data;
   logic              load_start;
   logic              busy, done, wr_err, coef_clk;
   logic [COEF_W-1:0] coef_out;
`ifdef FIR_COEF_CHECKSUM_EN
   logic [COEF_W-1:0] coef_sum;
   logic [COEF_W-1:0] exp_sum_q [$];
`endif

   fir_coef_loader #(.HALF(HALF)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .load_start (load_start),
      .busy       (busy),
      .done       (done),
      .wr_err     (wr_err),
      .coef_out   (coef_out),
      .coef_clk   (coef_clk)
`ifdef FIR_COEF_CHECKSUM_EN
      ,.coef_sum  (coef_sum)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   logic [COEF_W-1:0] model_buf [N_TAPS];
   logic [COEF_W-1:0] fir_chain [N_TAPS];
   logic [COEF_W-1:0] exp_words [$];
   logic [COEF_W-1:0] exp_taps  [$];
   int                err_q     [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   int   lat, rises, busy_cnt;
   bit   tracking = 0;
   logic prev_cc = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         exp_words.delete();
         exp_taps.delete();
`ifdef FIR_COEF_CHECKSUM_EN
         exp_sum_q.delete();
`endif
         tracking = 0;
         prev_cc  = 1'b0;
      end else begin
         if (tracking) begin
            lat++;
            if (busy) busy_cnt++;
         end
         if (coef_clk && !prev_cc) begin
            rises++;
            check("coef_word_expected", exp_words.size() > 0, 1);
            if (exp_words.size() > 0) check("coef_word", coef_out, exp_words.pop_front());
            for (int k = N_TAPS - 1; k > 0; k--) fir_chain[k] = fir_chain[k-1];
            fir_chain[0] = coef_out;
         end
         prev_cc = coef_clk;
         if (wr_err) begin
            check("wr_err_expected", err_q.size() > 0, 1);
            if (err_q.size() > 0) void'(err_q.pop_front());
         end
         if (done) begin
            check("done_while_loading", tracking, 1);
            if (tracking) begin
               check("done_latency", lat, LAT);
               check("rise_count", rises, N_TAPS);
               check("busy_cycles", busy_cnt, LAT - 1);
               check("busy_at_done", busy, 0);
               check("tap_queue", exp_taps.size() >= N_TAPS, 1);
               for (int k = 0; k < N_TAPS; k++)
                  if (exp_taps.size() > 0) check($sformatf("fir_tap%0d", k), fir_chain[k], exp_taps.pop_front());
`ifdef FIR_COEF_CHECKSUM_EN
               if (exp_sum_q.size() > 0) check("coef_sum", coef_sum, exp_sum_q.pop_front());
`endif
               tracking = 0;
            end
         end
         if (load_start && !busy && !done && !tracking) begin
            tracking = 1;
            lat      = 0;
            rises    = 0;
            busy_cnt = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic push_load();
      logic [COEF_W-1:0] s;
      s = '0;
      for (int k = N_TAPS - 1; k >= 0; k--) begin
         exp_words.push_back(model_buf[k]);
         s = s + model_buf[k];
      end
      for (int k = 0; k < N_TAPS; k++) exp_taps.push_back(model_buf[k]);
`ifdef FIR_COEF_CHECKSUM_EN
      exp_sum_q.push_back(s);
`endif
   endtask

   task automatic wr(input int a, input logic [COEF_W-1:0] d, input bit in_load);
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(a);
      wr_data = d;
      if (a < N_TAPS && !in_load) model_buf[a] = d;
      else err_q.push_back(1);
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic load(input bit with_wr, input logic [COEF_W-1:0] d);
      @(posedge clk); #1;
      if (with_wr) begin
         wr_en   = 1'b1;
         wr_addr = ADDR_W'(N_TAPS - 1);
         wr_data = d;
         model_buf[N_TAPS-1] = d;
      end
      push_load();
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      wr_en      = 1'b0;
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done) break;
      end
      if (i == 300) begin
         n_cmp++;
         n_fail++;
         $display("FAIL done_timeout: got no done expected done within 300 cycles");
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before 2ms");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; load_start = 1'b0;
      for (int k = 0; k < N_TAPS; k++) begin model_buf[k] = '0; fir_chain[k] = '0; end
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr_err", wr_err, 0);
      check("rst_coef_out", coef_out, 0);
      check("rst_coef_clk", coef_clk, 0);
      @(posedge clk); #1 reset = 1'b0;

      // empty buffer load
      load(0, '0);
      wait_done();

      // ramp pattern
      for (int k = 0; k < N_TAPS; k++) wr(k, 16'h0100 + 16'(k), 0);
      load(0, '0);
      wait_done();

      // out-of-range write, then write during busy
      wr(21, 16'hDEAD, 0);
      load(0, '0);
      wr(5, 16'h7777, 1);
      wait_done();
      load(0, '0);
      wait_done();

      // simultaneous write and load_start
      load(1, 16'hBEEF);
      wait_done();

      // reset mid-load
      load(0, '0);
      repeat (28) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("abort_coef_clk", coef_clk, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      @(posedge clk); #1 reset = 1'b0;
      for (int k = 0; k < N_TAPS; k++) model_buf[k] = '0;
      load(0, '0);
      wait_done();

`ifdef FIR_COEF_CHECKSUM_EN
      for (int k = 0; k < N_TAPS; k++) wr(k, 16'h1000, 0);
      load(0, '0);
      wait_done();
      load(0, '0);
      wait_done();
`endif

      repeat (5) @(posedge clk);
      #1;
      check("wr_err_pending", err_q.size(), 0);
      check("words_pending", exp_words.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
